// File: rtl/rm_lane_ordchk.sv
// Runtime-monitor lane: checks programmable "instr0 E0 at or before instr1 E1" ordering rules
// over a two-instruction window, with sticky per-rule status and first-failure capture.
module rm_lane_ordchk #(
    parameter int NUM_EVENTS = 32,
    parameter int NUM_ITYPES = 4,
    parameter int NUM_RULES  = 8,
    parameter int EVT_W      = 6,
    parameter int CYC_W      = 16,
    localparam int ITYPE_W   = (NUM_ITYPES > 1) ? $clog2(NUM_ITYPES) : 1,
    localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_EVENTS-1:0]                      lane_vector_i0,
    input  logic [NUM_EVENTS-1:0]                      lane_vector_i1,
    input  logic                                       valid0_from_alloc_i,
    input  logic [ITYPE_W-1:0]                         itype0_from_alloc_i,
    input  logic                                       valid0_i,
    input  logic                                       valid1_i,
    input  logic [ITYPE_W-1:0]                         itype1_i,
    input  logic                                       lane_reset_i,
    input  logic                                       hault,
    input  logic [NUM_RULES-1:0]                       cfg_rule_en_i,
    input  logic [NUM_RULES*EVT_W-1:0]                 cfg_e0_sel_i,
    input  logic [NUM_RULES*EVT_W-1:0]                 cfg_e1_sel_i,
    input  logic [NUM_RULES*NUM_ITYPES*NUM_ITYPES-1:0] cfg_pair_mask_i,
    output logic [NUM_RULES-1:0]                       rule_pass_o,
    output logic [NUM_RULES-1:0]                       rule_fail_o,
    output logic                                       any_fail_o,
    output logic                                       first_fail_valid_o,
    output logic [IDX_W-1:0]                           first_fail_idx_o,
    output logic [CYC_W-1:0]                           first_fail_cycle_o
);

    localparam int NUM_PAIRS = NUM_ITYPES * NUM_ITYPES;
    localparam int PAIR_W    = 2 * ITYPE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEN0,
        ST_PASS,
        ST_FAIL,
        ST_SKIP
    } rule_state_e;

    rule_state_e            state_q [NUM_RULES];
    rule_state_e            state_d [NUM_RULES];
    logic [ITYPE_W-1:0]     itype0_q, itype0_d;
    logic [CYC_W-1:0]       age_q, age_d;
    logic                   ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0]       ff_idx_q, ff_idx_d;
    logic [CYC_W-1:0]       ff_cycle_q, ff_cycle_d;
    logic [PAIR_W-1:0]      pair_idx;
    logic [NUM_RULES-1:0]   h0, h1, match, fail_now;
    logic [NUM_EVENTS-1:0]  vec0_sh, vec1_sh;
    logic [NUM_PAIRS-1:0]   mask_sh;

    assign pair_idx = PAIR_W'(itype0_q) * PAIR_W'(NUM_ITYPES) + PAIR_W'(itype1_i);

    // itype0 keeps following the allocator even while the lane is halted.
    always_comb begin
        itype0_d = itype0_q;
        if (lane_reset_i) begin
            itype0_d = '0;
        end else if (valid0_from_alloc_i) begin
            itype0_d = itype0_from_alloc_i;
        end
    end

    always_comb begin
        h0      = '0;
        h1      = '0;
        match   = '0;
        vec0_sh = '0;
        vec1_sh = '0;
        mask_sh = '0;
        // Shifting out-of-range selects leaves zero, so they never hit.
        for (int r = 0; r < NUM_RULES; r++) begin
            vec0_sh  = lane_vector_i0 >> cfg_e0_sel_i[r*EVT_W +: EVT_W];
            vec1_sh  = lane_vector_i1 >> cfg_e1_sel_i[r*EVT_W +: EVT_W];
            mask_sh  = cfg_pair_mask_i[r*NUM_PAIRS +: NUM_PAIRS] >> pair_idx;
            h0[r]    = valid0_i & vec0_sh[0];
            h1[r]    = valid1_i & vec1_sh[0];
            match[r] = mask_sh[0];
        end
    end

    always_comb begin
        fail_now = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            state_d[r] = state_q[r];
            if (lane_reset_i) begin
                state_d[r] = ST_IDLE;
            end else if (!hault && cfg_rule_en_i[r]) begin
                case (state_q[r])
                    ST_IDLE: begin
                        if (h1[r]) begin
                            if (match[r]) state_d[r] = h0[r] ? ST_PASS : ST_FAIL;
                            else          state_d[r] = ST_SKIP;
                        end else if (h0[r]) begin
                            state_d[r] = ST_SEEN0;
                        end
                    end
                    ST_SEEN0: begin
                        if (h1[r]) state_d[r] = match[r] ? ST_PASS : ST_SKIP;
                    end
                    default: state_d[r] = state_q[r];
                endcase
            end
            fail_now[r] = (state_d[r] == ST_FAIL) && (state_q[r] != ST_FAIL);
        end
    end

    always_comb begin
        age_d = age_q;
        if (lane_reset_i) begin
            age_d = '0;
        end else if (!hault && (age_q != {CYC_W{1'b1}})) begin
            age_d = age_q + CYC_W'(1);
        end
    end

    // Downward scan so the lowest failing index wins a same-cycle tie.
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_cycle_d = ff_cycle_q;
        if (lane_reset_i) begin
            ff_valid_d = 1'b0;
            ff_idx_d   = '0;
            ff_cycle_d = '0;
        end else if (!ff_valid_q && (|fail_now)) begin
            ff_valid_d = 1'b1;
            ff_cycle_d = age_q;
            for (int r = NUM_RULES - 1; r >= 0; r--) begin
                if (fail_now[r]) ff_idx_d = IDX_W'(r);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_RULES; r++) state_q[r] <= ST_IDLE;
            itype0_q   <= '0;
            age_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_cycle_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RULES; r++) state_q[r] <= state_d[r];
            itype0_q   <= itype0_d;
            age_q      <= age_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_cycle_q <= ff_cycle_d;
        end
    end

    always_comb begin
        rule_pass_o = '0;
        rule_fail_o = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            rule_pass_o[r] = (state_q[r] == ST_PASS);
            rule_fail_o[r] = (state_q[r] == ST_FAIL);
        end
    end

    assign any_fail_o         = |rule_fail_o;
    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_idx_o   = ff_idx_q;
    assign first_fail_cycle_o = ff_cycle_q;

endmodule

// File: tb/tb_rm_lane_ordchk.sv
// Directed self-checking bench for rm_lane_ordchk; a second instance with a 4-bit
// age counter exercises saturation of the first-failure cycle stamp.
module tb_rm_lane_ordchk;

    localparam int NR = 8;
    localparam int NE = 32;
    localparam int EW = 6;
    localparam int NP = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NE-1:0]   lane_vector_i0, lane_vector_i1;
    logic            valid0_from_alloc_i;
    logic [1:0]      itype0_from_alloc_i;
    logic            valid0_i, valid1_i;
    logic [1:0]      itype1_i;
    logic            lane_reset_i, hault;
    logic [NR-1:0]   cfg_rule_en_i;
    logic [NR*EW-1:0] cfg_e0_sel_i, cfg_e1_sel_i;
    logic [NR*NP-1:0] cfg_pair_mask_i;

    logic [NR-1:0]   rule_pass_o, rule_fail_o;
    logic            any_fail_o, first_fail_valid_o;
    logic [2:0]      first_fail_idx_o;
    logic [15:0]     first_fail_cycle_o;

    logic [NR-1:0]   sat_pass, sat_fail;
    logic            sat_any, sat_ffv;
    logic [2:0]      sat_idx;
    logic [3:0]      sat_cycle;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk_i = ~clk_i;

    rm_lane_ordchk dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lane_vector_i0(lane_vector_i0), .lane_vector_i1(lane_vector_i1),
        .valid0_from_alloc_i(valid0_from_alloc_i), .itype0_from_alloc_i(itype0_from_alloc_i),
        .valid0_i(valid0_i), .valid1_i(valid1_i), .itype1_i(itype1_i),
        .lane_reset_i(lane_reset_i), .hault(hault),
        .cfg_rule_en_i(cfg_rule_en_i), .cfg_e0_sel_i(cfg_e0_sel_i),
        .cfg_e1_sel_i(cfg_e1_sel_i), .cfg_pair_mask_i(cfg_pair_mask_i),
        .rule_pass_o(rule_pass_o), .rule_fail_o(rule_fail_o), .any_fail_o(any_fail_o),
        .first_fail_valid_o(first_fail_valid_o), .first_fail_idx_o(first_fail_idx_o),
        .first_fail_cycle_o(first_fail_cycle_o)
    );

    rm_lane_ordchk #(.CYC_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .lane_vector_i0(lane_vector_i0), .lane_vector_i1(lane_vector_i1),
        .valid0_from_alloc_i(valid0_from_alloc_i), .itype0_from_alloc_i(itype0_from_alloc_i),
        .valid0_i(valid0_i), .valid1_i(valid1_i), .itype1_i(itype1_i),
        .lane_reset_i(lane_reset_i), .hault(hault),
        .cfg_rule_en_i(cfg_rule_en_i), .cfg_e0_sel_i(cfg_e0_sel_i),
        .cfg_e1_sel_i(cfg_e1_sel_i), .cfg_pair_mask_i(cfg_pair_mask_i),
        .rule_pass_o(sat_pass), .rule_fail_o(sat_fail), .any_fail_o(sat_any),
        .first_fail_valid_o(sat_ffv), .first_fail_idx_o(sat_idx),
        .first_fail_cycle_o(sat_cycle)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One cycle of event hits; a negative bit index means no hit on that side.
    task automatic applyStimulus(input int e0_bit, input int e1_bit, input logic [1:0] it1);
        valid0_i       = (e0_bit >= 0);
        valid1_i       = (e1_bit >= 0);
        lane_vector_i0 = (e0_bit >= 0) ? (32'd1 << e0_bit) : '0;
        lane_vector_i1 = (e1_bit >= 0) ? (32'd1 << e1_bit) : '0;
        itype1_i       = it1;
        tick();
        valid0_i       = 1'b0;
        valid1_i       = 1'b0;
        lane_vector_i0 = '0;
        lane_vector_i1 = '0;
    endtask

    task automatic laneReset();
        lane_reset_i = 1'b1;
        tick();
        lane_reset_i = 1'b0;
    endtask

    task automatic loadType(input logic [1:0] t);
        valid0_from_alloc_i = 1'b1;
        itype0_from_alloc_i = t;
        tick();
        valid0_from_alloc_i = 1'b0;
    endtask

    task automatic setRule(input int r, input int e0, input int e1, input logic [15:0] mask);
        cfg_e0_sel_i[r*EW +: EW]    = 6'(e0);
        cfg_e1_sel_i[r*EW +: EW]    = 6'(e1);
        cfg_pair_mask_i[r*NP +: NP] = mask;
    endtask

    task automatic clearCfg();
        cfg_rule_en_i = '0;
        for (int r = 0; r < NR; r++) setRule(r, 63, 63, 16'h0000);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pass"}, 32'(rule_pass_o), 32'h0);
        checkOutput({tag, "_fail"}, 32'(rule_fail_o), 32'h0);
        checkOutput({tag, "_any"},  32'(any_fail_o), 32'h0);
        checkOutput({tag, "_ffv"},  32'(first_fail_valid_o), 32'h0);
        checkOutput({tag, "_idx"},  32'(first_fail_idx_o), 32'h0);
        checkOutput({tag, "_cyc"},  32'(first_fail_cycle_o), 32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        lane_vector_i0 = '0; lane_vector_i1 = '0;
        valid0_from_alloc_i = 1'b0; itype0_from_alloc_i = '0;
        valid0_i = 1'b0; valid1_i = 1'b0; itype1_i = '0;
        lane_reset_i = 1'b0; hault = 1'b0;
        cfg_e0_sel_i = '0; cfg_e1_sel_i = '0; cfg_pair_mask_i = '0;
        clearCfg();
        idle(2);
        rst_i = 1'b0;
        checkAllZero("reset");

        // Ordered pass
        setRule(0, 5, 7, 16'h0002);
        cfg_rule_en_i = 8'h01;
        laneReset();
        loadType(2'd0);
        idle(1);
        applyStimulus(5, -1, 2'd0);
        checkOutput("seen0_pass", 32'(rule_pass_o), 32'h0);
        idle(1);
        applyStimulus(-1, 7, 2'd1);
        checkOutput("ord_pass", 32'(rule_pass_o), 32'h01);
        checkOutput("ord_any", 32'(any_fail_o), 32'h0);

        // Order violation, e1 at age 2
        laneReset();
        checkOutput("lr_pass_clr", 32'(rule_pass_o), 32'h0);
        idle(2);
        applyStimulus(-1, 7, 2'd1);
        checkOutput("viol_fail", 32'(rule_fail_o), 32'h01);
        checkOutput("viol_any", 32'(any_fail_o), 32'h1);
        checkOutput("viol_ffv", 32'(first_fail_valid_o), 32'h1);
        checkOutput("viol_idx", 32'(first_fail_idx_o), 32'h0);
        checkOutput("viol_cyc", 32'(first_fail_cycle_o), 32'd2);
        applyStimulus(5, 7, 2'd1);
        checkOutput("viol_sticky", 32'(rule_fail_o), 32'h01);

        // Pair mismatch -> SKIP, and SKIP stays terminal after re-typing instr0
        laneReset();
        loadType(2'd2);
        applyStimulus(-1, 7, 2'd3);
        checkOutput("skip_pass", 32'(rule_pass_o), 32'h0);
        checkOutput("skip_fail", 32'(rule_fail_o), 32'h0);
        loadType(2'd0);
        applyStimulus(-1, 7, 2'd1);
        checkOutput("skip_term_fail", 32'(rule_fail_o), 32'h0);
        checkOutput("skip_ffv", 32'(first_fail_valid_o), 32'h0);

        // Simultaneous fails on rules 3 and 6, later rule 1
        clearCfg();
        setRule(3, 40, 10, 16'hFFFF);
        setRule(6, 40, 10, 16'hFFFF);
        setRule(1, 40, 12, 16'hFFFF);
        cfg_rule_en_i = 8'h4A;
        laneReset();
        applyStimulus(-1, 10, 2'd0);
        checkOutput("sim_fail", 32'(rule_fail_o), 32'h48);
        checkOutput("sim_idx", 32'(first_fail_idx_o), 32'd3);
        checkOutput("sim_cyc", 32'(first_fail_cycle_o), 32'd0);
        applyStimulus(-1, 12, 2'd0);
        checkOutput("late_fail", 32'(rule_fail_o), 32'h4A);
        checkOutput("late_idx", 32'(first_fail_idx_o), 32'd3);

        // hault freezes FSMs and age
        clearCfg();
        setRule(0, 5, 7, 16'h0002);
        setRule(2, 40, 15, 16'hFFFF);
        cfg_rule_en_i = 8'h05;
        laneReset();
        applyStimulus(5, -1, 2'd0);
        hault = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(-1, 7, 2'd1);
        checkOutput("hault_pass", 32'(rule_pass_o), 32'h0);
        checkOutput("hault_fail", 32'(rule_fail_o), 32'h0);
        hault = 1'b0;
        applyStimulus(-1, 7, 2'd1);
        checkOutput("unhault_pass", 32'(rule_pass_o), 32'h01);
        applyStimulus(-1, 15, 2'd0);
        checkOutput("hault_age_idx", 32'(first_fail_idx_o), 32'd2);
        checkOutput("hault_age_cyc", 32'(first_fail_cycle_o), 32'd2);

        // lane reset under hault also zeroes itype0 despite an allocator load
        hault = 1'b1;
        loadType(2'd3);
        lane_reset_i = 1'b1;
        valid0_from_alloc_i = 1'b1;
        itype0_from_alloc_i = 2'd2;
        tick();
        lane_reset_i = 1'b0;
        valid0_from_alloc_i = 1'b0;
        checkAllZero("lr_hault");
        hault = 1'b0;
        applyStimulus(5, 7, 2'd1);
        checkOutput("same_cycle_pass", 32'(rule_pass_o), 32'h01);

        // Age saturation
        laneReset();
        idle(20);
        applyStimulus(-1, 15, 2'd0);
        checkOutput("age20_cyc", 32'(first_fail_cycle_o), 32'd20);
        checkOutput("sat_ffv", 32'(sat_ffv), 32'h1);
        checkOutput("sat_idx", 32'(sat_idx), 32'd2);
        checkOutput("sat_cyc", 32'(sat_cycle), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
